seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning data width in bits, with legal range 4..64.
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  synchronous active-low reset.
REQ-005 in_valid  input  1  operand/opcode presented.
REQ-006 in_ready  output  1  block can accept an operation this cycle.
REQ-007 Ain, Bin  input  WIDTH  operands.
REQ-008 ALUop  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 NOTB, 100 OR, 101 XOR, 110 SHL, 111 MUL.
REQ-009 out  output  WIDTH  registered result.
REQ-010 Z, V, N  output  1 each  registered status flags for out.
REQ-011 out_valid  output  1  out/Z/V/N hold a valid result.
REQ-012 out_ready  input  1  consumer accepts the result.

Function
REQ-013 States SHALL be IDLE, BUSY and DONE.
REQ-014 An operation is accepted on a rising edge with in_valid=1 and in_ready=1; Ain, Bin and ALUop are captured on that edge.
REQ-015 in_ready SHALL be 1 in IDLE, 1 in DONE when out_ready=1, and 0 otherwise.
REQ-016 Ops ADD, SUB, AND, NOTB, OR, XOR and SHL SHALL go to DONE with out valid on the accept edge: 1-cycle latency.
REQ-017 ADD/SUB SHALL wrap modulo 2^WIDTH; NOTB = ~Bin; SHL = Ain << Bin[clog2(WIDTH)-1:0] with zero fill.
REQ-018 MUL SHALL go to BUSY and run an unsigned shift-add over exactly WIDTH cycles, then enter DONE, giving WIDTH+1 cycles from accept to out_valid.
REQ-019 MUL out SHALL be the low WIDTH bits of the 2*WIDTH product.
REQ-020 Z SHALL be 1 iff out==0, and N SHALL equal out[WIDTH-1], both for every op, independent of V.
REQ-021 V for ADD SHALL be 1 iff Ain and Bin have the same sign and the result sign differs.
REQ-022 V for SUB SHALL be 1 iff Ain and Bin have different signs and the result sign differs from Ain.
REQ-023 V for MUL SHALL be 1 iff the upper WIDTH product bits are nonzero.
REQ-024 V for all other ops SHALL be 0.
REQ-025 In DONE with out_ready=0, out/Z/V/N/out_valid SHALL hold stable; in_ready=0 and input changes are ignored.
REQ-026 DONE with out_ready=1 and in_valid=0 SHALL go to IDLE; out_valid drops next cycle.
REQ-027 DONE with out_ready=1 and in_valid=1 SHALL retire the result and accept the new op on the same edge, giving back-to-back single-cycle throughput.
REQ-028 In BUSY, in_ready=0 and out_valid=0; in_valid is ignored.

Reset
REQ-029 reset_n=0 at a rising edge SHALL force IDLE, out=0, Z=V=N=0, out_valid=0, and clear the multiplier state.
REQ-030 Reset SHALL abort an in-flight MUL or a pending unconsumed result with no output produced.
REQ-031 in_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-032 Opcode encodings (localparams or typedef enum ALU_ADD..ALU_MUL) and the state encoding SHALL live in the shared package alu_pkg.
REQ-033 The iterative multiplier SHALL be the sub-module seq_alu_mul, with start, a, b, done, product[2*WIDTH-1:0], WIDTH-parametrised, and sharing clk/reset_n.

Verification
REQ-034 (WIDTH=16) ADD 0x7FFF+0x0001 -> out=0x8000, V=1, N=1, Z=0, out_valid the cycle after accept.
REQ-035 SUB 0x1234-0x1234 -> out=0x0000, Z=1, V=0, N=0; SUB 0x8000-0x0001 -> out=0x7FFF, V=1, N=0.
REQ-036 MUL 0x0100*0x0003 -> out=0x0300, V=0, out_valid exactly 17 cycles after accept; MUL 0x0100*0x0100 -> out=0x0000, Z=1, V=1.
REQ-037 NOTB Bin=0x00FF -> 0xFF00, N=1. SHL Ain=0x0001, Bin=0x0013 -> 0x0008.
REQ-038 Back-pressure: hold out_ready=0 for 5 cycles -> out and flags stable, in_ready=0. Then out_ready=1 with in_valid=1 carrying ADD 2+3 -> new result 0x0005 valid next cycle, no bubble.
REQ-039 Assert reset_n=0 at cycle 8 of a MUL -> next cycle IDLE, out_valid=0, out=0, in_ready=1 after release; a following ADD 1+1 returns 0x0002.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | alu_pkg : opcode and FSM state encodings shared by seq_alu          |
// | rev 1.0                                                             |
// +---------------------------------------------------------------------+
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_NOTB = 3'b011,
    ALU_OR   = 3'b100,
    ALU_XOR  = 3'b101,
    ALU_SHL  = 3'b110,
    ALU_MUL  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } alu_state_e;

endpackage
`default_nettype wire

// File: rtl/seq_alu_mul.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | seq_alu_mul : unsigned shift-add multiplier, one bit per cycle      |
// | rev 1.0                                                             |
// +---------------------------------------------------------------------+
module seq_alu_mul #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [CW-1:0]    cnt;
  logic             busy;
  logic [WIDTH:0]   sum;

  // product is the value after this cycle's step, so the final result is
  // available in the same cycle that done is high.
  assign sum     = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
  assign product = {sum, lo[WIDTH-1:1]};
  assign done    = busy && (cnt == CW'(WIDTH-1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      mcand <= a;
      hi    <= '0;
      lo    <= b;
      cnt   <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      {hi, lo} <= product;
      cnt      <= cnt + 1'b1;
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | seq_alu : valid/ready ALU, single-cycle ops plus iterative multiply |
// | rev 1.0                                                             |
// +---------------------------------------------------------------------+
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  input  logic [2:0]       ALUop,
  output logic [WIDTH-1:0] out,
  output logic             Z,
  output logic             V,
  output logic             N,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_e         state;
  logic               accept;
  logic               is_mul;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_v;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (alu_op_e'(ALUop) == ALU_MUL);

  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    case (alu_op_e'(ALUop))
      ALU_ADD: begin
        alu_res = Ain + Bin;
        alu_v   = (Ain[WIDTH-1] == Bin[WIDTH-1]) && (alu_res[WIDTH-1] != Ain[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_res = Ain - Bin;
        alu_v   = (Ain[WIDTH-1] != Bin[WIDTH-1]) && (alu_res[WIDTH-1] != Ain[WIDTH-1]);
      end
      ALU_AND:  alu_res = Ain & Bin;
      ALU_NOTB: alu_res = ~Bin;
      ALU_OR:   alu_res = Ain | Bin;
      ALU_XOR:  alu_res = Ain ^ Bin;
      ALU_SHL:  alu_res = Ain << Bin[SHW-1:0];
      default:  alu_res = '0;
    endcase
  end

  seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (accept && is_mul),
    .a       (Ain),
    .b       (Bin),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      out       <= '0;
      Z         <= 1'b0;
      V         <= 1'b0;
      N         <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (is_mul) begin
              state     <= ST_BUSY;
              out_valid <= 1'b0;
            end else begin
              state     <= ST_DONE;
              out       <= alu_res;
              Z         <= ~|alu_res;
              V         <= alu_v;
              N         <= alu_res[WIDTH-1];
              out_valid <= 1'b1;
            end
          end else if ((state == ST_DONE) && out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (mul_done) begin
            state     <= ST_DONE;
            out       <= mul_product[WIDTH-1:0];
            Z         <= ~|mul_product[WIDTH-1:0];
            V         <= |mul_product[2*WIDTH-1:WIDTH];
            N         <= mul_product[WIDTH-1];
            out_valid <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | tb_seq_alu : directed corner cases plus random ops vs a model       |
// | rev 1.0                                                             |
// +---------------------------------------------------------------------+
module tb_seq_alu;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] Ain;
  logic [W-1:0] Bin;
  logic [2:0]   ALUop;
  logic [W-1:0] out;
  logic         Z;
  logic         V;
  logic         N;
  logic         out_valid;
  logic         out_ready;

  int n_vec = 0;
  int n_err = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Ain       (Ain),
    .Bin       (Bin),
    .ALUop     (ALUop),
    .out       (out),
    .Z         (Z),
    .V         (V),
    .N         (N),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: signed range test for ADD/SUB overflow, full-width product for MUL.
  function automatic logic [W:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    int          s;
    longint      p;
    logic [W-1:0] r;
    logic        v;
    r = '0;
    v = 1'b0;
    case (op)
      3'd0: begin
        s = int'($signed(a)) + int'($signed(b));
        r = s[W-1:0];
        v = (s > 32767) || (s < -32768);
      end
      3'd1: begin
        s = int'($signed(a)) - int'($signed(b));
        r = s[W-1:0];
        v = (s > 32767) || (s < -32768);
      end
      3'd2: r = a & b;
      3'd3: r = ~b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: r = a << (b % 16);
      default: begin
        p = longint'(a) * longint'(b);
        r = p[W-1:0];
        v = (p > 65535);
      end
    endcase
    return {v, r};
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] corner [4];
    corner = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
    return W'($urandom);
  endfunction

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    ALUop    = op;
    Ain      = a;
    Bin      = b;
    in_valid = 1'b1;
    #1;
    check("in_ready_at_issue", in_ready, 1);
    tick();
    in_valid = 1'b0;
    Ain      = W'($urandom);
    Bin      = W'($urandom);
    ALUop    = 3'($urandom);
  endtask

  task automatic await_result(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      check("busy_in_ready", in_ready, 0);
      tick();
      lat++;
    end
  endtask

  task automatic directed(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] r,
                          input logic [2:0] zvn, input int exp_lat);
    int lat;
    issue(op, a, b);
    await_result(lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_out"}, out, r);
    check({tag, "_zvn"}, {Z, V, N}, zvn);
    tick();
    check({tag, "_drop"}, out_valid, 0);
  endtask

  initial begin
    int           lat;
    logic [W:0]   m;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           hold;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    Ain       = '0;
    Bin       = '0;
    ALUop     = '0;
    repeat (3) tick();
    check("rst_out", out, 0);
    check("rst_zvn", {Z, V, N}, 0);
    check("rst_out_valid", out_valid, 0);
    reset_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);

    directed("add_ovf",  3'd0, 16'h7FFF, 16'h0001, 16'h8000, 3'b011, 1);
    directed("sub_zero", 3'd1, 16'h1234, 16'h1234, 16'h0000, 3'b100, 1);
    directed("sub_ovf",  3'd1, 16'h8000, 16'h0001, 16'h7FFF, 3'b010, 1);
    directed("mul_small",3'd7, 16'h0100, 16'h0003, 16'h0300, 3'b000, 17);
    directed("mul_ovf",  3'd7, 16'h0100, 16'h0100, 16'h0000, 3'b110, 17);
    directed("notb",     3'd3, 16'h5A5A, 16'h00FF, 16'hFF00, 3'b001, 1);
    directed("shl",      3'd6, 16'h0001, 16'h0013, 16'h0008, 3'b000, 1);

    // Back-pressure: result must hold while garbage is offered on the input.
    out_ready = 1'b0;
    a = pick();
    b = pick();
    m = model(3'd0, a, b);
    issue(3'd0, a, b);
    await_result(lat);
    check("bp_lat", lat, 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_out", out, m[W-1:0]);
      check("bp_zvn", {Z, V, N}, {m[W-1:0] == 0, m[W], m[W-1]});
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      in_valid = 1'b1;
      Ain      = W'($urandom);
      Bin      = W'($urandom);
      ALUop    = 3'($urandom);
      tick();
    end
    check("bp_out_end", out, m[W-1:0]);
    out_ready = 1'b1;
    issue(3'd0, 16'd2, 16'd3);
    check("b2b_valid", out_valid, 1);
    check("b2b_out", out, 16'h0005);
    tick();
    check("b2b_drop", out_valid, 0);

    // Reset in the eighth busy cycle of a multiply.
    issue(3'd7, 16'hFFFF, 16'hFFFF);
    repeat (7) tick();
    check("mid_mul_busy", out_valid, 0);
    reset_n = 1'b0;
    tick();
    check("abort_valid", out_valid, 0);
    check("abort_out", out, 0);
    check("abort_zvn", {Z, V, N}, 0);
    reset_n = 1'b1;
    #1;
    check("abort_in_ready", in_ready, 1);
    repeat (20) tick();
    check("abort_no_result", out_valid, 0);
    directed("add_after_rst", 3'd0, 16'h0001, 16'h0001, 16'h0002, 3'b000, 1);

    // Random ops, random hold times, mixing retire-to-idle with back-to-back.
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom);
      a  = pick();
      b  = pick();
      m  = model(op, a, b);
      out_ready = 1'b1;
      issue(op, a, b);
      await_result(lat);
      check("rnd_lat", lat, (op == 3'd7) ? 17 : 1);
      check("rnd_out", out, m[W-1:0]);
      check("rnd_zvn", {Z, V, N}, {m[W-1:0] == 0, m[W], m[W-1]});
      hold = $urandom_range(0, 3);
      if (hold > 0) begin
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
          in_valid = 1'($urandom);
          tick();
          check("rnd_hold_out", out, m[W-1:0]);
          check("rnd_hold_valid", out_valid, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      if ($urandom_range(0, 1) == 0) begin
        tick();
        check("rnd_drop", out_valid, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
